addr4u_pipe: RTL

ADDR4U_PIPE -- requirements
Module: addr4u_pipe

---
 rtl/addr4u_pkg.sv | 19 +
 rtl/addr4u_core.sv | 13 +
 rtl/addr4u_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/addr4u_pkg.sv
// Shared widths, S1 operand bundle and mod-3 helper for the addr4u pipe.
// Imported by addr4u_core and addr4u_pipe.
package addr4u_pkg;

  localparam int OPW     = 4;
  localparam int SUMW    = 5;
  localparam int ERRCNTW = 8;
  localparam int TXNCNTW = 16;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } s1_t;

  function automatic logic [1:0] mod3(input logic [SUMW-1:0] v);
    return 2'(v % SUMW'(3));
  endfunction

endpackage

// File: rtl/addr4u_core.sv
// Combinational 4-bit unsigned adder; any port-compatible variant may replace it.
// Ports: A[3:0], B[3:0] operands; O[4:0] sum with carry in bit 4.
module addr4u_core
  import addr4u_pkg::*;
(
  input  logic [OPW-1:0]  A,
  input  logic [OPW-1:0]  B,
  output logic [SUMW-1:0] O
);

  assign O = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/addr4u_pipe.sv
// Two-stage valid/ready pipe around addr4u_core with result/error counters.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b upstream;
// out_valid/out_ready/out_sum/out_err downstream; err_cnt, txn_cnt counters.
// Macro ADDR4U_RESCHK_EN adds a mod-3 residue check driving out_err/err_cnt.
module addr4u_pipe
  import addr4u_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW-1:0]     in_a,
  input  logic [OPW-1:0]     in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUMW-1:0]    out_sum,
  output logic               out_err,
  output logic [ERRCNTW-1:0] err_cnt,
  output logic [TXNCNTW-1:0] txn_cnt
);

  logic               s1_vld_q, s1_vld_d;
  s1_t                s1_q, s1_d;
  logic               s2_vld_q, s2_vld_d;
  logic [SUMW-1:0]    sum_q, sum_d;
  logic [TXNCNTW-1:0] txn_q, txn_d;
  logic [SUMW-1:0]    core_sum;
  logic               acc, s2_ld, fire;

  addr4u_core u_core (
    .A (s1_q.a),
    .B (s1_q.b),
    .O (core_sum)
  );

  always_comb begin
    s2_ld    = s1_vld_q & (~s2_vld_q | out_ready);
    fire     = s2_vld_q & out_ready;
    // held low while rst is high so nothing is taken in the reset cycle
    in_ready = ~rst & (~s1_vld_q | s2_ld);
    acc      = in_valid & in_ready;
    s1_vld_d = acc | (s1_vld_q & ~s2_ld);
    s1_d     = s1_q;
    if (acc) begin
      s1_d.a = in_a;
      s1_d.b = in_b;
    end
    s2_vld_d = s2_ld | (s2_vld_q & ~out_ready);
    sum_d    = s2_ld ? core_sum : sum_q;
    txn_d    = txn_q + TXNCNTW'(fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_vld_q <= 1'b0;
      sum_q    <= '0;
      txn_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
      s2_vld_q <= s2_vld_d;
      sum_q    <= sum_d;
      txn_q    <= txn_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_sum   = sum_q;
  assign txn_cnt   = txn_q;

`ifdef ADDR4U_RESCHK_EN
  logic               err_q, err_d, chk_err;
  logic [ERRCNTW-1:0] errc_q, errc_d;
  logic [1:0]         res_ab;

  always_comb begin
    res_ab  = mod3(SUMW'(mod3(SUMW'(s1_q.a)))
                 + SUMW'(mod3(SUMW'(s1_q.b))));
    chk_err = res_ab != mod3(core_sum);
    err_d   = s2_ld ? chk_err : err_q;
    errc_d  = errc_q;
    if (fire && err_q && errc_q != '1)
      errc_d = errc_q + ERRCNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      errc_q <= '0;
    end else begin
      err_q  <= err_d;
      errc_q <= errc_d;
    end
  end

  assign out_err = err_q;
  assign err_cnt = errc_q;
`else
  assign out_err = 1'b0;
  assign err_cnt = '0;
`endif

endmodule
